// File: rtl/fetch_ctrl.sv
// fetch_ctrl: stage-1 instruction-fetch controller.
// Issues one I-cache request at a time for the current PC and buffers the
// returned instructions, each tagged with its PC, for decode. It holds the PC
// register (pc_stall) until a request is accepted. A redirect flushes the
// buffer and drops any response still in flight.
module fetch_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_data,
  input  logic        redirect_valid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Legacy-compatible state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_WAIT = 2'd1;  // request accepted, response pending
  localparam logic [1:0] ST_DROP = 2'd2;  // response pending, to be discarded

  logic [1:0]       state_q,  state_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] data_mem_q [DEPTH];
  logic [31:0] pc_mem_q   [DEPTH];

  logic fire;
  logic push;
  logic pop;

  // Request side: one outstanding fetch, only with room in the buffer.
  // Gating with reset_n keeps the request quiet while reset is held.
  assign icache_req_valid = reset_n & (state_q == ST_IDLE) & (count_q < DEPTH_C)
                            & ~redirect_valid;
  assign icache_addr      = pc_in;
  assign fire             = icache_req_valid & icache_req_ready;

  // The PC register advances on an accepted fetch or loads the redirect
  // target; it is always held during reset.
  assign pc_stall = ~reset_n | ~(fire | redirect_valid);

  // A response is only kept in WAIT and only without a same-cycle redirect;
  // a response in IDLE (protocol violation) or DROP never reaches the buffer.
  assign push = (state_q == ST_WAIT) & icache_resp_valid & ~redirect_valid;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign pop        = inst_valid & inst_ready;

  // Next-state logic of the fetch FSM and the captured request PC
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_in;
        end
      end
      ST_WAIT: begin
        // A response ends the transaction whether or not it is kept;
        // a redirect without the response must still swallow it later.
        if (icache_resp_valid) begin
          state_d = ST_IDLE;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (icache_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-state logic of the instruction buffer pointers and occupancy
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      // Flush takes priority over any same-cycle push or pop
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: FSM, request PC, buffer pointers and count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer storage: write the tagged instruction at the tail on a push
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= icache_resp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  // Occupancy never exceeds the buffer size
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count_q <= DEPTH_C);

  // A push into a full buffer would require a second outstanding request
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (count_q < DEPTH_C));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: drives the I-cache side by hand and
// keeps a scoreboard of the {pc, data} pairs decode is expected to receive.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        redirect_valid;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [63:0] sb[$];

  fetch_ctrl #(.DEPTH(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_in             (pc_in),
    .pc_stall          (pc_stall),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_addr       (icache_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .redirect_valid    (redirect_valid),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_data         (inst_data),
    .inst_pc           (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Decode side: pop the scoreboard whenever the DUT hands over an entry
  always @(negedge clk) begin
    if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e[63:32]);
        chk("inst_data", inst_data, e[31:0]);
      end
    end
  end

  // One complete fetch: request accepted at once, response one cycle later
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
    pc_in            = pc;
    icache_req_ready = 1'b1;
    settle();
    chk("fo_req_valid", 32'(icache_req_valid), 32'd1);
    chk("fo_addr", icache_addr, pc);
    chk("fo_stall_fire", 32'(pc_stall), 32'd0);
    tick();
    icache_req_ready  = 1'b0;
    pc_in             = pc + 32'd4;
    icache_resp_valid = 1'b1;
    icache_resp_data  = data;
    sb.push_back({pc, data});
    settle();
    chk("fo_stall_wait", 32'(pc_stall), 32'd1);
    chk("fo_noreq_wait", 32'(icache_req_valid), 32'd0);
    tick();
    icache_resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n           = 1'b0;
    pc_in             = '0;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;
    redirect_valid    = 1'b0;
    inst_ready        = 1'b0;

    // Reset values, including a stalled PC even with redirect raised
    #3;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    redirect_valid   = 1'b1;
    icache_req_ready = 1'b1;
    #1;
    chk("rst_stall_redir", 32'(pc_stall), 32'd1);
    chk("rst_req_redir", 32'(icache_req_valid), 32'd0);
    redirect_valid   = 1'b0;
    icache_req_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back fetches with decode always ready
    inst_ready = 1'b1;
    fetch_one(32'h0000_2000, 32'h0000_0013);
    settle();
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    fetch_one(32'h0000_2004, 32'h00A0_0093);
    settle();
    chk("t1_inst_valid2", 32'(inst_valid), 32'd1);
    tick();
    settle();
    chk("t1_drained", 32'(inst_valid), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Decode stalled: buffer fills, requests stop, then drain and resume
    inst_ready = 1'b0;
    fetch_one(32'h0000_3000, 32'h1111_1111);
    fetch_one(32'h0000_3004, 32'h2222_2222);
    icache_req_ready = 1'b1;
    settle();
    chk("t2_full_req", 32'(icache_req_valid), 32'd0);
    chk("t2_full_stall", 32'(pc_stall), 32'd1);
    chk("t2_full_valid", 32'(inst_valid), 32'd1);
    tick();
    settle();
    chk("t2_full_req2", 32'(icache_req_valid), 32'd0);
    icache_req_ready = 1'b0;
    inst_ready       = 1'b1;
    tick();
    settle();
    chk("t2_resume_req", 32'(icache_req_valid), 32'd1);
    chk("t2_resume_addr", icache_addr, 32'h0000_3008);
    tick();
    settle();
    chk("t2_empty", 32'(inst_valid), 32'd0);
    fetch_one(32'h0000_3008, 32'h3333_3333);
    tick();
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect while WAIT, response three cycles later is dropped
    pc_in            = 32'h0000_4000;
    icache_req_ready = 1'b1;
    settle();
    chk("t3_req", 32'(icache_req_valid), 32'd1);
    tick();
    pc_in          = 32'h0000_4004;
    redirect_valid = 1'b1;
    sb.delete();
    settle();
    chk("t3_redir_stall", 32'(pc_stall), 32'd0);
    chk("t3_redir_noreq", 32'(icache_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    pc_in          = 32'h0000_5000;
    settle();
    chk("t3_drop_noreq", 32'(icache_req_valid), 32'd0);
    chk("t3_drop_stall", 32'(pc_stall), 32'd1);
    tick();
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_BEEF;
    settle();
    chk("t3_drop_noreq2", 32'(icache_req_valid), 32'd0);
    tick();
    icache_resp_valid = 1'b0;
    icache_req_ready  = 1'b0;
    settle();
    chk("t3_no_inst", 32'(inst_valid), 32'd0);
    chk("t3_newpc_req", 32'(icache_req_valid), 32'd1);
    chk("t3_newpc_addr", icache_addr, 32'h0000_5000);
    fetch_one(32'h0000_5000, 32'h4444_4444);
    tick();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect and response together with one entry buffered
    inst_ready = 1'b0;
    fetch_one(32'h0000_6000, 32'h5555_5555);
    pc_in            = 32'h0000_6004;
    icache_req_ready = 1'b1;
    settle();
    tick();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'h6666_6666;
    redirect_valid    = 1'b1;
    sb.delete();
    settle();
    chk("t4_redir_stall", 32'(pc_stall), 32'd0);
    tick();
    icache_resp_valid = 1'b0;
    redirect_valid    = 1'b0;
    settle();
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    chk("t4_idle_req", 32'(icache_req_valid), 32'd1);

    // Cache not ready for four cycles: request and address hold steady
    pc_in = 32'h0000_7000;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t5_hold_valid", 32'(icache_req_valid), 32'd1);
      chk("t5_hold_addr", icache_addr, 32'h0000_7000);
      chk("t5_hold_stall", 32'(pc_stall), 32'd1);
      tick();
    end
    fetch_one(32'h0000_7000, 32'h7777_7777);

    // Reset in the middle of WAIT with a buffered entry
    pc_in            = 32'h0000_7004;
    icache_req_ready = 1'b1;
    settle();
    chk("t6_req", 32'(icache_req_valid), 32'd1);
    tick();
    icache_req_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_req", 32'(icache_req_valid), 32'd0);
    chk("t6_rst_stall", 32'(pc_stall), 32'd1);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hBAD0_BAD0;
    settle();
    chk("t6_idle_req", 32'(icache_req_valid), 32'd1);
    tick();
    icache_resp_valid = 1'b0;
    settle();
    chk("t6_stray_ignored", 32'(inst_valid), 32'd0);
    tick();
    settle();
    chk("t6_stray_ignored2", 32'(inst_valid), 32'd0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
